response_packetizer: RTL and testbench

RESPONSE_PACKETIZER -- requirements
Module: response_packetizer

---
 rtl/response_packetizer.sv | 141 ++++++++++++++
 tb/tb_response_packetizer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/response_packetizer.sv
// Serialises one frame of PUF response words into UART bytes:
// header, every word MSB byte first, then an XOR checksum of the word bytes.
module response_packetizer #(
  parameter int unsigned RESPONSE_BITS = 32,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_WORDS     = 1280,
  parameter logic [7:0]  RESPONSE_ID   = 8'b10101010
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     fifo_empty,
  input  logic [RESPONSE_BITS-1:0] fifo_dout,
  output logic                     fifo_rd_en,
  input  logic                     tx_busy,
  output logic                     tx_enable,
  output logic [DATA_BITS-1:0]     tx_data,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned BYTES = RESPONSE_BITS / DATA_BITS;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_HI, WAIT_LO, FETCH, CAPTURE, NEXT, DONE
  } state_t;

  typedef enum logic [1:0] {
    BYTE_HDR, BYTE_WORD, BYTE_SUM
  } kind_t;

  state_t                   state, state_nxt;
  kind_t                    kind, kind_nxt;
  logic [RESPONSE_BITS-1:0] word_reg, word_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [DATA_BITS-1:0]     sum, sum_nxt, data_nxt;
  logic [DATA_BITS-1:0]     word_top, fifo_top;

  // The word register shifts left, so the next byte to send is always on top.
  assign word_top = word_reg[RESPONSE_BITS-1 -: DATA_BITS];
  assign fifo_top = fifo_dout[RESPONSE_BITS-1 -: DATA_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      kind     <= BYTE_HDR;
      word_reg <= '0;
      idx      <= '0;
      cnt      <= '0;
      sum      <= '0;
      tx_data  <= '0;
    end else begin
      state    <= state_nxt;
      kind     <= kind_nxt;
      word_reg <= word_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      sum      <= sum_nxt;
      tx_data  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    kind_nxt   = kind;
    word_nxt   = word_reg;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    sum_nxt    = sum;
    data_nxt   = tx_data;
    fifo_rd_en = 1'b0;
    tx_enable  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = SEND;
          kind_nxt  = BYTE_HDR;
          data_nxt  = DATA_BITS'(RESPONSE_ID);
          cnt_nxt   = '0;
          idx_nxt   = '0;
          sum_nxt   = '0;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_enable = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: if (tx_busy)  state_nxt = WAIT_LO;
      WAIT_LO: if (!tx_busy) state_nxt = NEXT;
      FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = CAPTURE;
        end
      end
      CAPTURE: begin
        word_nxt  = fifo_dout << DATA_BITS;
        data_nxt  = fifo_top;
        sum_nxt   = sum ^ fifo_top;
        idx_nxt   = '0;
        cnt_nxt   = cnt + 1'b1;
        kind_nxt  = BYTE_WORD;
        state_nxt = SEND;
      end
      NEXT: begin
        if (kind == BYTE_SUM) begin
          state_nxt = DONE;
        end else if (kind == BYTE_HDR || idx == IDX_W'(BYTES - 1)) begin
          if (cnt < CNT_W'(NUM_WORDS)) begin
            state_nxt = FETCH;
          end else begin
            kind_nxt  = BYTE_SUM;
            data_nxt  = sum;
            state_nxt = SEND;
          end
        end else begin
          idx_nxt   = idx + 1'b1;
          data_nxt  = word_top;
          word_nxt  = word_reg << DATA_BITS;
          sum_nxt   = sum ^ word_top;
          state_nxt = SEND;
        end
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_response_packetizer.sv
// Bench for response_packetizer: two instances (2-word and 1-word frames)
// with a FIFO model, a UART busy model and a queue-based frame reference.
module tb_response_packetizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start      [2];
  logic        fifo_empty [2];
  logic [31:0] fifo_dout  [2];
  logic        fifo_rd_en [2];
  logic        tx_busy    [2];
  logic        tx_enable  [2];
  logic [7:0]  tx_data    [2];
  logic        busy       [2];
  logic        done       [2];

  response_packetizer #(.RESPONSE_BITS(32), .DATA_BITS(8), .NUM_WORDS(2), .RESPONSE_ID(8'hAA)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[0]), .fifo_empty(fifo_empty[0]), .fifo_dout(fifo_dout[0]),
    .fifo_rd_en(fifo_rd_en[0]), .tx_busy(tx_busy[0]), .tx_enable(tx_enable[0]), .tx_data(tx_data[0]),
    .busy(busy[0]), .done(done[0]));

  response_packetizer #(.RESPONSE_BITS(32), .DATA_BITS(8), .NUM_WORDS(1), .RESPONSE_ID(8'hAA)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .fifo_empty(fifo_empty[1]), .fifo_dout(fifo_dout[1]),
    .fifo_rd_en(fifo_rd_en[1]), .tx_busy(tx_busy[1]), .tx_enable(tx_enable[1]), .tx_data(tx_data[1]),
    .busy(busy[1]), .done(done[1]));

  // Environment model state
  logic [31:0] mem [2][8];
  int          fifo_n [2];
  int          fifo_rd [2];
  logic        hold_empty [2];
  logic        force_busy [2];
  int          uart_cyc [2];
  int          ucnt [2];
  logic [7:0]  latched [2];
  logic [7:0]  sent [2][32];
  int          sent_n [2];
  int          rd_pulses [2];
  int          done_n [2];
  int          rd_viol [2];
  int          tx_viol [2];

  logic [7:0]  exp_q [$];
  int          total = 0;
  int          bad = 0;

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      fifo_empty[g] = hold_empty[g] || (fifo_rd[g] >= fifo_n[g]);
      tx_busy[g]    = (ucnt[g] != 0) || force_busy[g];
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        ucnt[g] <= 0; fifo_rd[g] <= 0; sent_n[g] <= 0; rd_pulses[g] <= 0;
        done_n[g] <= 0; rd_viol[g] <= 0; tx_viol[g] <= 0; fifo_dout[g] <= '0;
      end else begin
        if (fifo_rd_en[g]) begin
          if (fifo_empty[g]) rd_viol[g] <= rd_viol[g] + 1;
          fifo_dout[g] <= mem[g][fifo_rd[g] % 8];
          fifo_rd[g]   <= fifo_rd[g] + 1;
          rd_pulses[g] <= rd_pulses[g] + 1;
        end
        if (tx_enable[g]) begin
          if (tx_busy[g]) tx_viol[g] <= tx_viol[g] + 1;
          sent[g][sent_n[g] % 32] <= tx_data[g];
          sent_n[g]  <= sent_n[g] + 1;
          latched[g] <= tx_data[g];
          ucnt[g]    <= uart_cyc[g];
        end else if (ucnt[g] != 0) begin
          ucnt[g] <= ucnt[g] - 1;
          if (tx_data[g] !== latched[g]) tx_viol[g] <= tx_viol[g] + 1;
        end
        if (done[g]) done_n[g] <= done_n[g] + 1;
      end
    end
  end

  // Expected frame straight from the framing rules.
  task automatic build_exp(input int g, input int nw);
    logic [7:0] cs, b;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    cs = 8'h00;
    for (int w = 0; w < nw; w++) begin
      for (int k = 3; k >= 0; k--) begin
        b = 8'(mem[g][w] >> (8 * k));
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; hold_empty[g] = 1'b0; force_busy[g] = 1'b0;
      fifo_n[g] = 0; uart_cyc[g] = 10;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_random(input int g, input int nw);
    for (int i = 0; i < nw; i++) mem[g][i] = $urandom;
    fifo_n[g] = nw;
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done[g]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_sent(input int g, input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sent_n[g] >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({fifo_rd_en[g], tx_enable[g], busy[g], done[g]} !== 4'b0000 || tx_data[g] !== 8'h00) begin
        bad++;
        $display("FAIL reset_outputs inst=%0d got rd=%b en=%b busy=%b done=%b data=%h want all 0",
                 g, fifo_rd_en[g], tx_enable[g], busy[g], done[g], tx_data[g]);
      end
    end
  endtask

  task automatic test_known_frame();
    bit ok;
    logic [7:0] lit [10] = '{8'hAA, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00};
    apply_reset();
    mem[0][0] = 32'h01234567; mem[0][1] = 32'h89ABCDEF; fifo_n[0] = 2;
    exp_q.delete();
    foreach (lit[i]) exp_q.push_back(lit[i]);
    pulse_start(0);
    wait_done(0, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL known_done_timeout got=0 want=1"); end
    repeat (5) @(negedge clk);
    total++;
    if (sent_n[0] !== exp_q.size()) begin bad++; $display("FAIL known_len got=%0d want=%0d", sent_n[0], exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent_n[0]; i++) begin
      total++;
      if (sent[0][i] !== exp_q[i]) begin bad++; $display("FAIL known_byte%0d got=%h want=%h", i, sent[0][i], exp_q[i]); end
    end
    total++; if (done_n[0] !== 1) begin bad++; $display("FAIL known_done_count got=%0d want=1", done_n[0]); end
    total++; if (rd_pulses[0] !== 2) begin bad++; $display("FAIL known_rd_count got=%0d want=2", rd_pulses[0]); end
    total++; if (rd_viol[0] !== 0) begin bad++; $display("FAIL known_rd_when_empty got=%0d want=0", rd_viol[0]); end
  endtask

  task automatic test_single_word();
    bit ok;
    int low_busy;
    logic [7:0] lit [6] = '{8'hAA, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    apply_reset();
    mem[1][0] = 32'hDEADBEEF; fifo_n[1] = 1;
    exp_q.delete();
    foreach (lit[i]) exp_q.push_back(lit[i]);
    pulse_start(1);
    low_busy = 0; ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done[1]) begin ok = 1'b1; break; end
      if (busy[1] !== 1'b1) low_busy++;
      @(negedge clk);
    end
    total++; if (!ok) begin bad++; $display("FAIL single_done_timeout got=0 want=1"); end
    total++; if (low_busy !== 0) begin bad++; $display("FAIL single_busy_gaps got=%0d want=0", low_busy); end
    total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL single_busy_at_done got=%b want=0", busy[1]); end
    repeat (3) @(negedge clk);
    total++;
    if (sent_n[1] !== exp_q.size()) begin bad++; $display("FAIL single_len got=%0d want=%0d", sent_n[1], exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent_n[1]; i++) begin
      total++;
      if (sent[1][i] !== exp_q[i]) begin bad++; $display("FAIL single_byte%0d got=%h want=%h", i, sent[1][i], exp_q[i]); end
    end
    total++; if (rd_pulses[1] !== 1) begin bad++; $display("FAIL single_rd_count got=%0d want=1", rd_pulses[1]); end
  endtask

  task automatic test_random_frames();
    bit ok;
    for (int it = 0; it < 5; it++) begin
      apply_reset();
      uart_cyc[0] = $urandom_range(1, 12);
      load_random(0, 2);
      build_exp(0, 2);
      pulse_start(0);
      wait_done(0, 3000, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand%0d_done_timeout got=0 want=1", it); end
      repeat (3) @(negedge clk);
      total++;
      if (sent_n[0] !== exp_q.size()) begin bad++; $display("FAIL rand%0d_len got=%0d want=%0d", it, sent_n[0], exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < sent_n[0]; i++) begin
        total++;
        if (sent[0][i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_byte%0d got=%h want=%h", it, i, sent[0][i], exp_q[i]); end
      end
      total++; if (tx_viol[0] !== 0) begin bad++; $display("FAIL rand%0d_tx_protocol got=%0d want=0", it, tx_viol[0]); end
    end
  endtask

  task automatic test_fifo_stall();
    bit ok;
    int rd_seen, en_seen;
    apply_reset();
    load_random(0, 2);
    build_exp(0, 2);
    hold_empty[0] = 1'b1;
    pulse_start(0);
    wait_sent(0, 1, 500, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_header_timeout got=0 want=1"); end
    rd_seen = 0; en_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_rd_en[0]) rd_seen++;
      if (tx_enable[0]) en_seen++;
    end
    total++; if (rd_seen !== 0) begin bad++; $display("FAIL stall_rd_en got=%0d want=0", rd_seen); end
    total++; if (en_seen !== 0) begin bad++; $display("FAIL stall_tx_enable got=%0d want=0", en_seen); end
    hold_empty[0] = 1'b0;
    wait_done(0, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_done_timeout got=0 want=1"); end
    repeat (3) @(negedge clk);
    total++;
    if (sent_n[0] !== exp_q.size()) begin bad++; $display("FAIL stall_len got=%0d want=%0d", sent_n[0], exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent_n[0]; i++) begin
      total++;
      if (sent[0][i] !== exp_q[i]) begin bad++; $display("FAIL stall_byte%0d got=%h want=%h", i, sent[0][i], exp_q[i]); end
    end
    total++; if (rd_viol[0] !== 0) begin bad++; $display("FAIL stall_rd_when_empty got=%0d want=0", rd_viol[0]); end
  endtask

  task automatic test_tx_busy_hold();
    bit ok;
    int en_seen;
    apply_reset();
    load_random(0, 2);
    build_exp(0, 2);
    force_busy[0] = 1'b1;
    pulse_start(0);
    en_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_enable[0]) en_seen++;
    end
    total++; if (en_seen !== 0) begin bad++; $display("FAIL hold_tx_enable got=%0d want=0", en_seen); end
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b want=1", busy[0]); end
    force_busy[0] = 1'b0;
    wait_done(0, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL hold_done_timeout got=0 want=1"); end
    repeat (3) @(negedge clk);
    total++;
    if (sent_n[0] !== exp_q.size()) begin bad++; $display("FAIL hold_len got=%0d want=%0d", sent_n[0], exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent_n[0]; i++) begin
      total++;
      if (sent[0][i] !== exp_q[i]) begin bad++; $display("FAIL hold_byte%0d got=%h want=%h", i, sent[0][i], exp_q[i]); end
    end
    total++; if (tx_viol[0] !== 0) begin bad++; $display("FAIL hold_tx_stability got=%0d want=0", tx_viol[0]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    load_random(0, 2);
    pulse_start(0);
    wait_sent(0, 4, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_reach_timeout got=0 want=1"); end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({fifo_rd_en[0], tx_enable[0], busy[0], done[0]} !== 4'b0000 || tx_data[0] !== 8'h00) begin
      bad++;
      $display("FAIL midrst_outputs got rd=%b en=%b busy=%b done=%b data=%h want all 0",
               fifo_rd_en[0], tx_enable[0], busy[0], done[0], tx_data[0]);
    end
    reset = 1'b0;
    load_random(0, 2);
    build_exp(0, 2);
    pulse_start(0);
    wait_done(0, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_done_timeout got=0 want=1"); end
    repeat (3) @(negedge clk);
    total++;
    if (sent_n[0] !== exp_q.size()) begin bad++; $display("FAIL midrst_len got=%0d want=%0d", sent_n[0], exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent_n[0]; i++) begin
      total++;
      if (sent[0][i] !== exp_q[i]) begin bad++; $display("FAIL midrst_byte%0d got=%h want=%h", i, sent[0][i], exp_q[i]); end
    end
  endtask

  task automatic test_start_spam();
    bit ok;
    int busy_after;
    apply_reset();
    load_random(0, 2);
    build_exp(0, 2);
    @(negedge clk);
    start[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done[0]) begin
        start[0] = 1'b1;
        ok = 1'b1;
        break;
      end
      start[0] = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    start[0] = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL spam_done_timeout got=0 want=1"); end
    busy_after = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy[0] || tx_enable[0]) busy_after++;
    end
    total++; if (busy_after !== 0) begin bad++; $display("FAIL spam_restarted got=%0d want=0", busy_after); end
    total++; if (done_n[0] !== 1) begin bad++; $display("FAIL spam_done_count got=%0d want=1", done_n[0]); end
    total++;
    if (sent_n[0] !== exp_q.size()) begin bad++; $display("FAIL spam_len got=%0d want=%0d", sent_n[0], exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < sent_n[0]; i++) begin
      total++;
      if (sent[0][i] !== exp_q[i]) begin bad++; $display("FAIL spam_byte%0d got=%h want=%h", i, sent[0][i], exp_q[i]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; hold_empty[g] = 1'b0; force_busy[g] = 1'b0;
      fifo_n[g] = 0; uart_cyc[g] = 10; latched[g] = 8'h00;
    end
    test_reset();
    test_known_frame();
    test_single_word();
    test_random_frames();
    test_fifo_stall();
    test_tx_busy_hold();
    test_reset_mid();
    test_start_spam();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
